// File: rtl/spi_px_stream_bridge.sv
// SPI-slave pixel bridge: MOSI words feed an input FIFO streamed to the core;
// core results fill an output FIFO that is shifted back out on MISO.
module spi_px_stream_bridge #(
   parameter int unsigned CH_BITS    = 8,
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned OUT_BITS   = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                      clk_i,
   input  logic                      nreset_i,
   input  logic                      spi_sck_i,
   input  logic                      spi_cs_i,
   input  logic                      spi_sdi_i,
   output logic                      spi_sdo_o,
   output logic [CH_BITS*NUM_CH-1:0] in_px_o,
   output logic                      in_px_valid_o,
   input  logic                      in_px_ready_i,
   input  logic [OUT_BITS-1:0]       out_px_i,
   input  logic                      out_px_valid_i,
   output logic                      out_px_ready_o,
   input  logic                      clr_flags_i,
   output logic                      rx_overflow_o,
   output logic                      tx_underflow_o
);
   localparam int unsigned IN_W  = CH_BITS * NUM_CH;
   localparam int unsigned RXC_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int unsigned TXC_W = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [1:0]          sck_sync_q, cs_sync_q, sdi_sync_q;
   logic                sck_prev_q, cs_prev_q;
   logic                sck_s, cs_s, sdi_s;
   logic                sck_rise_c, sck_fall_c, cs_fall_c, cs_rise_c;

   logic [IN_W-1:0]     rx_sr_q, rx_sr_d;
   logic [RXC_W-1:0]    rx_cnt_q, rx_cnt_d;
   logic                rx_push_q, rx_push_d;
   logic [OUT_BITS-1:0] tx_sr_q, tx_sr_d;
   logic [TXC_W-1:0]    tx_cnt_q, tx_cnt_d;
   logic                tx_load_c;
   logic                sdo_q, sdo_d;
   logic                ovf_q, ovf_d, unf_q, unf_d;

   logic [IN_W-1:0]     in_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    in_wr_q, in_wr_d, in_rd_q, in_rd_d;
   logic [LVL_W-1:0]    in_lvl_q, in_lvl_d;
   logic                in_valid_q, in_full_c, in_push_c, in_pop_c;

   logic [OUT_BITS-1:0] out_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
   logic [LVL_W-1:0]    out_lvl_q, out_lvl_d;
   logic                out_ready_q, out_empty_c, out_push_c, out_pop_c;

   assign sck_s = sck_sync_q[1];
   assign cs_s  = cs_sync_q[1];
   assign sdi_s = sdi_sync_q[1];

   // sck edges only count inside a selected frame
   assign sck_rise_c = ~cs_s & sck_s & ~sck_prev_q;
   assign sck_fall_c = ~cs_s & ~sck_s & sck_prev_q;
   assign cs_fall_c  = ~cs_s & cs_prev_q;
   assign cs_rise_c  = cs_s & ~cs_prev_q;

   assign in_full_c   = (in_lvl_q == LVL_W'(FIFO_DEPTH));
   assign in_pop_c    = in_valid_q & in_px_ready_i;
   assign in_push_c   = rx_push_q & (~in_full_c | in_pop_c);
   assign out_empty_c = (out_lvl_q == '0);
   assign out_push_c  = out_px_valid_i & out_ready_q;
   assign out_pop_c   = tx_load_c & ~out_empty_c;

   // Serial shift/count control and sticky flags
   always_comb begin
      rx_sr_d   = rx_sr_q;
      rx_cnt_d  = rx_cnt_q;
      rx_push_d = 1'b0;
      tx_sr_d   = tx_sr_q;
      tx_cnt_d  = tx_cnt_q;
      tx_load_c = 1'b0;
      if (cs_rise_c) begin
         rx_sr_d  = '0;
         rx_cnt_d = '0;
         tx_cnt_d = '0;
      end else begin
         if (sck_rise_c) begin
            rx_sr_d = {rx_sr_q[IN_W-2:0], sdi_s};
            if (rx_cnt_q == RXC_W'(IN_W - 1)) begin
               rx_cnt_d  = '0;
               rx_push_d = 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + RXC_W'(1);
            end
         end
         if (cs_fall_c || (sck_fall_c && tx_cnt_q == TXC_W'(OUT_BITS - 1))) begin
            tx_load_c = 1'b1;
            tx_sr_d   = out_empty_c ? '0 : out_mem_q[out_rd_q];
            tx_cnt_d  = '0;
         end else if (sck_fall_c) begin
            tx_sr_d  = tx_sr_q << 1;
            tx_cnt_d = tx_cnt_q + TXC_W'(1);
         end
      end
      sdo_d = ~cs_s & tx_sr_d[OUT_BITS-1];
      ovf_d = (rx_push_q & in_full_c & ~in_pop_c) | (ovf_q & ~clr_flags_i);
      unf_d = (tx_load_c & out_empty_c) | (unf_q & ~clr_flags_i);
   end

   // FIFO pointer and level bookkeeping
   always_comb begin
      in_wr_d   = in_wr_q;
      in_rd_d   = in_rd_q;
      in_lvl_d  = in_lvl_q;
      out_wr_d  = out_wr_q;
      out_rd_d  = out_rd_q;
      out_lvl_d = out_lvl_q;
      if (in_push_c) in_wr_d = in_wr_q + PTR_W'(1);
      if (in_pop_c)  in_rd_d = in_rd_q + PTR_W'(1);
      if (in_push_c && !in_pop_c)      in_lvl_d = in_lvl_q + LVL_W'(1);
      else if (!in_push_c && in_pop_c) in_lvl_d = in_lvl_q - LVL_W'(1);
      if (out_push_c) out_wr_d = out_wr_q + PTR_W'(1);
      if (out_pop_c)  out_rd_d = out_rd_q + PTR_W'(1);
      if (out_push_c && !out_pop_c)      out_lvl_d = out_lvl_q + LVL_W'(1);
      else if (!out_push_c && out_pop_c) out_lvl_d = out_lvl_q - LVL_W'(1);
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;
         sdi_sync_q  <= '0;
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b1;
         rx_sr_q     <= '0;
         rx_cnt_q    <= '0;
         rx_push_q   <= 1'b0;
         tx_sr_q     <= '0;
         tx_cnt_q    <= '0;
         sdo_q       <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         in_mem_q    <= '{default: '0};
         in_wr_q     <= '0;
         in_rd_q     <= '0;
         in_lvl_q    <= '0;
         in_valid_q  <= 1'b0;
         out_mem_q   <= '{default: '0};
         out_wr_q    <= '0;
         out_rd_q    <= '0;
         out_lvl_q   <= '0;
         out_ready_q <= 1'b1;
      end else begin
         sck_sync_q  <= {sck_sync_q[0], spi_sck_i};
         cs_sync_q   <= {cs_sync_q[0], spi_cs_i};
         sdi_sync_q  <= {sdi_sync_q[0], spi_sdi_i};
         sck_prev_q  <= sck_s;
         cs_prev_q   <= cs_s;
         rx_sr_q     <= rx_sr_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_push_q   <= rx_push_d;
         tx_sr_q     <= tx_sr_d;
         tx_cnt_q    <= tx_cnt_d;
         sdo_q       <= sdo_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         if (in_push_c) in_mem_q[in_wr_q] <= rx_sr_q;
         if (out_push_c) out_mem_q[out_wr_q] <= out_px_i;
         in_wr_q     <= in_wr_d;
         in_rd_q     <= in_rd_d;
         in_lvl_q    <= in_lvl_d;
         in_valid_q  <= (in_lvl_d != '0);
         out_wr_q    <= out_wr_d;
         out_rd_q    <= out_rd_d;
         out_lvl_q   <= out_lvl_d;
         out_ready_q <= (out_lvl_d != LVL_W'(FIFO_DEPTH));
      end
   end

   assign spi_sdo_o      = sdo_q;
   assign in_px_o        = in_mem_q[in_rd_q];
   assign in_px_valid_o  = in_valid_q;
   assign out_px_ready_o = out_ready_q;
   assign rx_overflow_o  = ovf_q;
   assign tx_underflow_o = unf_q;

endmodule

// File: tb/tb_spi_px_stream_bridge.sv
// Bench for spi_px_stream_bridge: vector table, directed corner sequences and
// a randomized phase checked against a queue-based model of both FIFOs.
module tb_spi_px_stream_bridge;
   logic        clk = 1'b0;
   logic        nreset, spi_sck, spi_cs, spi_sdi, spi_sdo;
   logic [23:0] in_px;
   logic        in_valid, in_ready;
   logic [7:0]  out_px;
   logic        out_valid, out_ready, clr;
   logic        ovf, unf;

   int n_tests = 0;
   int n_fail  = 0;

   spi_px_stream_bridge dut (
      .clk_i          (clk),
      .nreset_i       (nreset),
      .spi_sck_i      (spi_sck),
      .spi_cs_i       (spi_cs),
      .spi_sdi_i      (spi_sdi),
      .spi_sdo_o      (spi_sdo),
      .in_px_o        (in_px),
      .in_px_valid_o  (in_valid),
      .in_px_ready_i  (in_ready),
      .out_px_i       (out_px),
      .out_px_valid_i (out_valid),
      .out_px_ready_o (out_ready),
      .clr_flags_i    (clr),
      .rx_overflow_o  (ovf),
      .tx_underflow_o (unf)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [23:0] px;
      logic [7:0]  tx;
      logic [23:0] exp_px;
      logic [23:0] exp_miso;
   } vec_t;

   vec_t vecs [4];

   // reference model state
   logic [23:0] m_in [$];
   logic [7:0]  m_out [$];
   logic        m_ovf, m_unf;

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input bit first, input logic b, output logic s);
      if (!first) spi_sck = 1'b0;
      spi_sdi = b;
      wait_clk(4);
      s = spi_sdo;
      spi_sck = 1'b1;
      wait_clk(4);
   endtask

   task automatic cs_end();
      spi_cs = 1'b1;
      wait_clk(4);
      spi_sck = 1'b0;
      wait_clk(4);
   endtask

   task automatic spi_frame(input int nbits, input logic [127:0] mosi, output logic [127:0] miso);
      logic s;
      miso = '0;
      spi_cs = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         send_bit(i == 0, mosi[nbits-1-i], s);
         miso[nbits-1-i] = s;
      end
      cs_end();
   endtask

   task automatic push_out(input logic [7:0] d);
      out_px = d;
      out_valid = 1'b1;
      wait_clk(1);
      out_valid = 1'b0;
   endtask

   task automatic pop_check(input string name, input logic [23:0] exp);
      check({name, " valid"}, 64'(in_valid), 64'(1));
      check({name, " data"}, 64'(in_px), 64'(exp));
      in_ready = 1'b1;
      wait_clk(1);
      in_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      wait_clk(1);
      clr = 1'b0;
   endtask

   initial begin
      logic [127:0] miso, big, exp;
      logic [23:0]  w [5];
      logic [23:0]  p2;
      logic [7:0]   miso8, d;
      logic         s;
      int           lat, op, npx, nbits;

      vecs[0] = '{24'hA1B2C3, 8'h5A, 24'hA1B2C3, 24'h5A0000};
      vecs[1] = '{24'h000000, 8'hFF, 24'h000000, 24'hFF0000};
      vecs[2] = '{24'hFFFFFF, 8'h00, 24'hFFFFFF, 24'h000000};
      vecs[3] = '{24'h800001, 8'h81, 24'h800001, 24'h810000};

      nreset = 1'b0; spi_sck = 1'b0; spi_cs = 1'b1; spi_sdi = 1'b0;
      in_ready = 1'b0; out_px = '0; out_valid = 1'b0; clr = 1'b0;
      wait_clk(3);
      check("reset sdo", 64'(spi_sdo), 64'(0));
      check("reset in_valid", 64'(in_valid), 64'(0));
      check("reset out_ready", 64'(out_ready), 64'(1));
      check("reset ovf", 64'(ovf), 64'(0));
      check("reset unf", 64'(unf), 64'(0));
      nreset = 1'b1;
      wait_clk(4);

      // table: one rx pixel and one tx byte per frame
      for (int i = 0; i < 4; i++) begin
         push_out(vecs[i].tx);
         spi_frame(24, 128'(vecs[i].px), miso);
         check("vec miso", 64'(miso[23:0]), 64'(vecs[i].exp_miso));
         check("vec underflow", 64'(unf), 64'(1));
         pop_check("vec px", vecs[i].exp_px);
         check("vec drained", 64'(in_valid), 64'(0));
         pulse_clr();
      end

      // RX with latency bound after the last rise
      p2 = 24'hA1B2C3;
      spi_cs = 1'b0;
      for (int i = 0; i < 23; i++) send_bit(i == 0, p2[23-i], s);
      spi_sck = 1'b0; spi_sdi = p2[0];
      wait_clk(4);
      spi_sck = 1'b1;
      lat = 0;
      while (!in_valid && lat < 8) begin
         wait_clk(1);
         lat++;
      end
      check("rx valid in time", 64'(in_valid), 64'(1));
      check("rx word", 64'(in_px), 64'(24'hA1B2C3));
      wait_clk(4);
      cs_end();
      in_ready = 1'b1;
      wait_clk(1);
      in_ready = 1'b0;
      check("rx valid drops", 64'(in_valid), 64'(0));

      // TX two queued bytes
      pulse_clr();
      push_out(8'h5A);
      push_out(8'h3C);
      spi_frame(16, 128'h0, miso);
      check("tx miso", 64'(miso[15:0]), 64'(16'h5A3C));
      check("tx no underflow", 64'(unf), 64'(0));
      check("tx partial rx dropped", 64'(in_valid), 64'(0));

      // overflow: five pixels into depth 4
      for (int k = 0; k < 5; k++) w[k] = 24'($urandom);
      big = 128'({w[0], w[1], w[2], w[3], w[4]});
      spi_frame(120, big, miso);
      check("ovf set", 64'(ovf), 64'(1));
      for (int k = 0; k < 4; k++) pop_check("ovf fifo", w[k]);
      check("ovf drained", 64'(in_valid), 64'(0));
      pulse_clr();
      check("ovf cleared", 64'(ovf), 64'(0));

      // abort after 10 bits, then a clean frame
      spi_frame(10, 128'h3FF, miso);
      check("abort no push", 64'(in_valid), 64'(0));
      spi_frame(24, 128'h010203, miso);
      pop_check("abort next", 24'h010203);
      check("abort single", 64'(in_valid), 64'(0));
      pulse_clr();

      // underflow plus push/pop on a full input FIFO
      for (int k = 0; k < 5; k++) w[k] = 24'($urandom);
      big = 128'({w[0], w[1], w[2], w[3], w[4]});
      miso8 = '0;
      spi_cs = 1'b0;
      for (int i = 0; i < 119; i++) begin
         send_bit(i == 0, big[119-i], s);
         if (i < 8) miso8[7-i] = s;
      end
      spi_sck = 1'b0; spi_sdi = big[0];
      wait_clk(4);
      spi_sck = 1'b1;
      wait_clk(3);
      check("full valid", 64'(in_valid), 64'(1));
      check("full head", 64'(in_px), 64'(w[0]));
      in_ready = 1'b1;
      wait_clk(1);
      in_ready = 1'b0;
      wait_clk(4);
      cs_end();
      check("unf miso", 64'(miso8), 64'(0));
      check("unf set", 64'(unf), 64'(1));
      check("full push accepted", 64'(ovf), 64'(0));
      for (int k = 1; k < 5; k++) pop_check("full order", w[k]);
      check("full drained", 64'(in_valid), 64'(0));
      pulse_clr();

      // reset in the middle of a frame
      spi_frame(24, 128'h0ABCDE, miso);
      push_out(8'hAA); push_out(8'h55); push_out(8'hAA); push_out(8'h55);
      spi_cs = 1'b0;
      for (int i = 0; i < 5; i++) send_bit(i == 0, 1'b1, s);
      push_out(8'h99);
      check("pre-reset out full", 64'(out_ready), 64'(0));
      check("pre-reset in valid", 64'(in_valid), 64'(1));
      nreset = 1'b0;
      #1;
      check("midrst sdo", 64'(spi_sdo), 64'(0));
      check("midrst in_valid", 64'(in_valid), 64'(0));
      check("midrst out_ready", 64'(out_ready), 64'(1));
      check("midrst ovf", 64'(ovf), 64'(0));
      check("midrst unf", 64'(unf), 64'(0));
      wait_clk(2);
      spi_cs = 1'b1; spi_sck = 1'b0;
      wait_clk(2);
      nreset = 1'b1;
      wait_clk(4);
      check("postrst in_valid", 64'(in_valid), 64'(0));
      spi_frame(24, 128'h123456, miso);
      check("postrst miso", 64'(miso[23:0]), 64'(0));
      check("postrst unf", 64'(unf), 64'(1));
      pop_check("postrst px", 24'h123456);
      check("postrst drained", 64'(in_valid), 64'(0));
      pulse_clr();

      // randomized phase against the queue model
      m_in.delete(); m_out.delete();
      m_ovf = 1'b0; m_unf = 1'b0;
      for (int it = 0; it < 60; it++) begin
         op = int'($urandom_range(0, 3));
         case (op)
            0: begin
               npx = int'($urandom_range(1, 2));
               nbits = 24 * npx;
               for (int k = 0; k < npx; k++) w[k] = 24'($urandom);
               big = (npx == 1) ? 128'(w[0]) : 128'({w[0], w[1]});
               exp = '0;
               for (int j = 0; j < 3 * npx; j++) begin
                  if (m_out.size() > 0) d = m_out.pop_front();
                  else begin
                     d = 8'h00;
                     m_unf = 1'b1;
                  end
                  exp[nbits-1-8*j -: 8] = d;
               end
               for (int k = 0; k < npx; k++) begin
                  if (m_in.size() < 4) m_in.push_back(w[k]);
                  else m_ovf = 1'b1;
               end
               spi_frame(nbits, big, miso);
               check("rand miso", miso[63:0], exp[63:0]);
            end
            1: begin
               if (m_in.size() > 0) pop_check("rand pop", m_in.pop_front());
               else begin
                  check("rand empty", 64'(in_valid), 64'(0));
                  in_ready = 1'b1;
                  wait_clk(1);
                  in_ready = 1'b0;
               end
            end
            2: begin
               d = 8'($urandom);
               check("rand out_ready", 64'(out_ready), 64'(m_out.size() < 4));
               push_out(d);
               if (m_out.size() < 4) m_out.push_back(d);
            end
            default: begin
               pulse_clr();
               m_ovf = 1'b0;
               m_unf = 1'b0;
            end
         endcase
         check("rand ovf", 64'(ovf), 64'(m_ovf));
         check("rand unf", 64'(unf), 64'(m_unf));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
